// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter.
//   - arb_state_e : arbiter FSM state encoding (IDLE, SERVE0, SERVE1)
//   - DEF_WIDTH   : default data word width (matches the 4-bit FIFO)
//   - DEF_BURST_MAX / DEF_BURST_W : default burst length and counter width
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_e;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_BURST_MAX = 8;
    localparam int DEF_BURST_W   = 8;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with bounded bursts placing two producers onto
// the single write port of a synchronous FIFO. Stalls on fifo_full without
// dropping or duplicating words.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req0/req1  in   requester N has a word on dataN
//   data0/1    in   requester words (WIDTH bits)
//   fifo_full  in   FIFO full flag
//   gnt0/gnt1  out  registered: requester N owns the write port
//   ack0/ack1  out  combinational: requester N word accepted this cycle
//   write      out  combinational: FIFO write strobe
//   fifo_in    out  combinational: FIFO write data
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int BURST_W   = DEF_BURST_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             fifo_full,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             write,
    output logic [WIDTH-1:0] fifo_in
);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic               rr_last_q, rr_last_d;   // 0: requester 0 last served, 1: requester 1
    logic               gnt0_q, gnt1_q;
    logic               last_beat_s;

    // Grants come straight from flops, so an async reset kills acks/write at once.
    assign ack0    = gnt0_q & req0 & ~fifo_full;
    assign ack1    = gnt1_q & req1 & ~fifo_full;
    assign write   = ack0 | ack1;
    assign fifo_in = gnt1_q ? data1 : data0;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;

    // The word being acked now is the BURST_MAX-th of this grant.
    assign last_beat_s = (beat_cnt_q == BURST_W'(BURST_MAX - 1));

    // Next-state logic: grant selection, burst counting and round-robin pointer.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rr_last_d  = rr_last_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    // Tie goes to whoever was not served most recently.
                    state_d = rr_last_q ? SERVE0 : SERVE1;
                end else if (req0) begin
                    state_d = SERVE0;
                end else if (req1) begin
                    state_d = SERVE1;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE0: begin
                if (!req0 || (ack0 && last_beat_s)) begin
                    rr_last_d  = 1'b0;
                    beat_cnt_d = '0;
                    if (req1) begin
                        state_d = SERVE1;
                    end else if (req0) begin
                        state_d = SERVE0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ack0) begin
                    beat_cnt_d = beat_cnt_q + BURST_W'(1);
                end else begin
                    // Stalled on fifo_full: hold grant and count.
                    beat_cnt_d = beat_cnt_q;
                end
            end
            SERVE1: begin
                if (!req1 || (ack1 && last_beat_s)) begin
                    rr_last_d  = 1'b1;
                    beat_cnt_d = '0;
                    if (req0) begin
                        state_d = SERVE0;
                    end else if (req1) begin
                        state_d = SERVE1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ack1) begin
                    beat_cnt_d = beat_cnt_q + BURST_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State, burst counter, round-robin pointer and registered grants.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rr_last_q  <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rr_last_q  <= rr_last_d;
            gnt0_q     <= (state_d == SERVE0);
            gnt1_q     <= (state_d == SERVE1);
        end
    end

endmodule : fifo_wr_arbiter
